// File: rtl/fx3_slave_fifo_writer_if.sv
// Pixel-stream input and FX3 slave-FIFO write port of fx3_slave_fifo_writer.
// master = the writer itself, slave = upstream source plus FX3 model.
interface fx3_slave_fifo_writer_if;
    logic [31:0] data_i;
    logic        data_valid_i;
    logic        frame_sync_i;
    logic [31:0] fx3_data_o;
    logic        fx3_slwr_n_o;
    logic        fx3_pktend_n_o;
    logic [1:0]  fx3_addr_o;
    logic        fx3_ready_i;
    logic        overflow_o;
    logic [15:0] frame_count_o;

    modport master (
        input  data_i, data_valid_i, frame_sync_i, fx3_ready_i,
        output fx3_data_o, fx3_slwr_n_o, fx3_pktend_n_o, fx3_addr_o,
        output overflow_o, frame_count_o
    );

    modport slave (
        output data_i, data_valid_i, frame_sync_i, fx3_ready_i,
        input  fx3_data_o, fx3_slwr_n_o, fx3_pktend_n_o, fx3_addr_o,
        input  overflow_o, frame_count_o
    );
endinterface

// File: rtl/fx3_slave_fifo_writer.sv
// FX3 slave-FIFO writer: word FIFO, ping-pong DMA thread switching, short-packet frame end.
// Optional frame header words are enabled by defining FRAME_HEADER_EN.

// Generic word FIFO, first-word-fall-through read.
// Latency: write to rd_dat visible 1 clock later; empty/full from registered pointers.
// Backpressure: none upstream; writes while full are discarded, caller sees full.
module fx3_sfw_fifo #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_ok;

    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty  = (wr_ptr == rd_ptr);
    assign wr_en  = wr_vld && !full;
    assign rd_ok  = rd_en && !empty;
    assign rd_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
endmodule

// Streams buffered pixel words onto the FX3 GPIF bus, switching DMA thread every BUFFER_WORDS.
// Latency: FIFO pop to fx3_data_o/fx3_slwr_n_o is 1 registered clock.
// Backpressure: stalls on fx3_ready_i low or address settle; upstream overflow drops words and flags.
module fx3_slave_fifo_writer #(
    parameter int FIFO_DEPTH   = 512,
    parameter int BUFFER_WORDS = 4096,
    parameter int ADDR_SETTLE  = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    fx3_slave_fifo_writer_if.master bus
);
    localparam int BCW = $clog2(BUFFER_WORDS + 1);
    localparam int SCW = $clog2(ADDR_SETTLE + 2);
    localparam logic [BCW-1:0] BUF_LAST    = BCW'(BUFFER_WORDS - 1);
    localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(ADDR_SETTLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_SWITCH,
        S_PKTEND,
`ifdef FRAME_HEADER_EN
        S_HEADER,
`endif
        S_DONE
    } state_t;

    state_t         state;
    logic           fs_q;
    logic           end_pending;
    logic [BCW-1:0] buf_cnt;
    logic [SCW-1:0] settle_cnt;
    logic [31:0]    data_q;
    logic           slwr_n_q;
    logic           pktend_n_q;
    logic [1:0]     addr_q;
    logic           overflow_q;
    logic [15:0]    frame_cnt_q;

    logic [31:0]    fifo_rd_dat;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fs_rise;
    logic           fs_fall;
    logic           can_wr;
    logic           pop;

    assign fs_rise = bus.frame_sync_i && !fs_q;
    assign fs_fall = !bus.frame_sync_i && fs_q;
    // FX3 ready is only meaningful once the thread address has settled
    assign can_wr  = bus.fx3_ready_i && (settle_cnt == '0);
    assign pop     = (state == S_STREAM) && !fifo_empty && can_wr;

`ifdef FRAME_HEADER_EN
    localparam logic [15:0] BUF_WORDS16 = 16'(BUFFER_WORDS);
    logic        hdr_idx;
    logic [31:0] hdr_word;
    assign hdr_word = hdr_idx ? {overflow_q, 15'b0, BUF_WORDS16} : {16'hF5A5, frame_cnt_q};
`endif

    fx3_sfw_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk    (clk_i),
        .rst    (rst_i),
        .wr_vld (bus.data_valid_i),
        .wr_dat (bus.data_i),
        .rd_en  (pop),
        .rd_dat (fifo_rd_dat),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            fs_q        <= 1'b0;
            end_pending <= 1'b0;
            buf_cnt     <= '0;
            settle_cnt  <= '0;
            data_q      <= '0;
            slwr_n_q    <= 1'b1;
            pktend_n_q  <= 1'b1;
            addr_q      <= 2'd0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
`ifdef FRAME_HEADER_EN
            hdr_idx     <= 1'b0;
`endif
        end else begin
            fs_q       <= bus.frame_sync_i;
            slwr_n_q   <= 1'b1;
            pktend_n_q <= 1'b1;
            if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
            if (fs_rise && state != S_IDLE) end_pending <= 1'b1;
            // Blank too short: flag it, let the current frame finish
            if (fs_fall && state != S_IDLE) overflow_q <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (fs_fall) begin
                        overflow_q  <= 1'b0;
                        end_pending <= 1'b0;
`ifdef FRAME_HEADER_EN
                        hdr_idx     <= 1'b0;
                        state       <= S_HEADER;
`else
                        state       <= S_STREAM;
`endif
                    end
                end
`ifdef FRAME_HEADER_EN
                S_HEADER: begin
                    if (can_wr) begin
                        data_q   <= hdr_word;
                        slwr_n_q <= 1'b0;
                        buf_cnt  <= buf_cnt + 1'b1;
                        hdr_idx  <= !hdr_idx;
                        if (buf_cnt == BUF_LAST) state <= S_SWITCH;
                        else if (hdr_idx)        state <= S_STREAM;
                    end
                end
`endif
                S_STREAM: begin
                    if (pop) begin
                        data_q   <= fifo_rd_dat;
                        slwr_n_q <= 1'b0;
                        buf_cnt  <= buf_cnt + 1'b1;
                        if (buf_cnt == BUF_LAST) state <= S_SWITCH;
                    end else if (end_pending && fifo_empty) begin
                        state <= S_PKTEND;
                    end
                end
                S_SWITCH: begin
                    addr_q     <= {1'b0, !addr_q[0]};
                    buf_cnt    <= '0;
                    settle_cnt <= SETTLE_LOAD;
                    state      <= S_STREAM;
                end
                S_PKTEND: begin
                    // Partial buffer is committed with a short packet; a full one already went out
                    if (buf_cnt == '0) begin
                        state <= S_DONE;
                    end else if (can_wr) begin
                        pktend_n_q <= 1'b0;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    frame_cnt_q <= frame_cnt_q + 16'd1;
                    addr_q      <= {1'b0, !addr_q[0]};
                    buf_cnt     <= '0;
                    settle_cnt  <= SETTLE_LOAD;
                    end_pending <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Write side sees registered full: a same-cycle pop does not save the word
            if (bus.data_valid_i && fifo_full) overflow_q <= 1'b1;
        end
    end

    assign bus.fx3_data_o     = data_q;
    assign bus.fx3_slwr_n_o   = slwr_n_q;
    assign bus.fx3_pktend_n_o = pktend_n_q;
    assign bus.fx3_addr_o     = addr_q;
    assign bus.overflow_o     = overflow_q;
    assign bus.frame_count_o  = frame_cnt_q;
endmodule
